// File: rtl/event_dispatcher_if.sv
// Event dispatcher bus: raw event inputs, software ack/mask strobes and the
// registered dispatch results, grouped so the block has a single bus port.
interface event_dispatcher_if #(
    parameter int NUM_INPUTS = 64
);
    logic [NUM_INPUTS-1:0] event_signals;
    logic [15:0]           data_in;
    logic                  ack_load;
    logic                  mask_set_load;
    logic                  mask_clr_load;
    logic [15:0]           priority_out;
    logic                  event_pending;
    logic                  overflow_any;
    logic [NUM_INPUTS-1:0] pending_out;

    modport master (
        output event_signals,
        output data_in,
        output ack_load,
        output mask_set_load,
        output mask_clr_load,
        input  priority_out,
        input  event_pending,
        input  overflow_any,
        input  pending_out
    );

    modport slave (
        input  event_signals,
        input  data_in,
        input  ack_load,
        input  mask_set_load,
        input  mask_clr_load,
        output priority_out,
        output event_pending,
        output overflow_any,
        output pending_out
    );
endinterface

// File: rtl/event_dispatcher.sv
// Captures edge/level events per channel, tracks missed events, and registers
// the most urgent enabled pending channel index (channel 0 most urgent).
module event_dispatcher #(
    parameter int          NUM_INPUTS   = 64,
    parameter int          TOP_INPUT    = NUM_INPUTS - 1,
    parameter logic [63:0] LEVEL_MASK   = 64'h0,
    parameter logic [63:0] ENABLE_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [15:0] NONE_CODE    = 16'hFFFF
) (
    input logic               sysclk,
    input logic               sysreset,
    event_dispatcher_if.slave bus
);

    logic [NUM_INPUTS-1:0] chan_in;
    logic [NUM_INPUTS-1:0] set_vec;
    logic [NUM_INPUTS-1:0] ack_hit;
    logic [NUM_INPUTS-1:0] mask_set_hit;
    logic [NUM_INPUTS-1:0] mask_clr_hit;

    logic [NUM_INPUTS-1:0] last_q, last_d;
    logic [NUM_INPUTS-1:0] capture_q, capture_d;
    logic [NUM_INPUTS-1:0] overflow_q, overflow_d;
    logic [NUM_INPUTS-1:0] mask_q, mask_d;
    logic [NUM_INPUTS-1:0] pending_q, pending_d;
    logic [15:0]           priority_q, priority_d;
    logic                  event_pending_q, event_pending_d;
    logic                  overflow_any_q, overflow_any_d;

    // Input bus is MSB-first: the leftmost concatenated signal is channel 0.
    always_comb begin
        chan_in      = '0;
        set_vec      = '0;
        ack_hit      = '0;
        mask_set_hit = '0;
        mask_clr_hit = '0;
        for (int c = 0; c < NUM_INPUTS; c++) begin
            chan_in[c]      = bus.event_signals[TOP_INPUT - c];
            ack_hit[c]      = bus.ack_load      && (bus.data_in == 16'(c));
            mask_set_hit[c] = bus.mask_set_load && (bus.data_in == 16'(c));
            mask_clr_hit[c] = bus.mask_clr_load && (bus.data_in == 16'(c));
            set_vec[c]      = LEVEL_MASK[c] ? chan_in[c] : (chan_in[c] & ~last_q[c]);
        end
    end

    // A new event beats a same-cycle ack, so the old event is treated as acked.
    always_comb begin
        last_d     = chan_in;
        capture_d  = '0;
        overflow_d = '0;
        mask_d     = '0;
        for (int c = 0; c < NUM_INPUTS; c++) begin
            capture_d[c] = set_vec[c] | (capture_q[c] & ~ack_hit[c]);
            mask_d[c]    = mask_set_hit[c] | (mask_q[c] & ~mask_clr_hit[c]);
            if (LEVEL_MASK[c]) begin
                overflow_d[c] = 1'b0;
            end else if (set_vec[c] && capture_q[c] && !ack_hit[c]) begin
                overflow_d[c] = 1'b1;
            end else if (ack_hit[c] && !set_vec[c]) begin
                overflow_d[c] = 1'b0;
            end else begin
                overflow_d[c] = overflow_q[c];
            end
        end
    end

    always_comb begin
        priority_d = NONE_CODE;
        for (int c = NUM_INPUTS - 1; c >= 0; c--) begin
            if (capture_q[c] && mask_q[c]) begin
                priority_d = 16'(c);
            end
        end
        event_pending_d = (priority_d != NONE_CODE);
        overflow_any_d  = |overflow_q;
        pending_d       = capture_q;
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            last_q          <= '0;
            capture_q       <= '0;
            overflow_q      <= '0;
            mask_q          <= ENABLE_RESET[NUM_INPUTS-1:0];
            pending_q       <= '0;
            priority_q      <= NONE_CODE;
            event_pending_q <= 1'b0;
            overflow_any_q  <= 1'b0;
        end else begin
            last_q          <= last_d;
            capture_q       <= capture_d;
            overflow_q      <= overflow_d;
            mask_q          <= mask_d;
            pending_q       <= pending_d;
            priority_q      <= priority_d;
            event_pending_q <= event_pending_d;
            overflow_any_q  <= overflow_any_d;
        end
    end

    assign bus.priority_out  = priority_q;
    assign bus.event_pending = event_pending_q;
    assign bus.overflow_any  = overflow_any_q;
    assign bus.pending_out   = pending_q;

endmodule

// File: tb/tb_event_dispatcher.sv
// Directed bench for event_dispatcher: 64 channels, channel 1 level-sensitive,
// all others rising-edge; expected values are worked out by hand per step.
module tb_event_dispatcher;

    localparam logic [15:0] NONE = 16'hFFFF;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    event_dispatcher_if #(.NUM_INPUTS(64)) bus ();

    event_dispatcher #(
        .NUM_INPUTS  (64),
        .LEVEL_MASK  (64'h2),
        .ENABLE_RESET(64'hFFFF_FFFF_FFFF_FFFF),
        .NONE_CODE   (16'hFFFF)
    ) dut (
        .sysclk  (clk),
        .sysreset(rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Channel c lives at bit 63-c of the input bus.
    function automatic logic [63:0] chan(input int c);
        logic [63:0] one;
        one = 64'd1;
        return one << (63 - c);
    endfunction

    // Drive one cycle's inputs, then step just past the next rising edge.
    task automatic applyStimulus(input logic [63:0] ev, input logic [15:0] idx,
                                 input logic ack, input logic mset, input logic mclr);
        bus.event_signals = ev;
        bus.data_in       = idx;
        bus.ack_load      = ack;
        bus.mask_set_load = mset;
        bus.mask_clr_load = mclr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b1;
        bus.event_signals = '0;
        bus.data_in       = '0;
        bus.ack_load      = 1'b0;
        bus.mask_set_load = 1'b0;
        bus.mask_clr_load = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_priority", 64'(bus.priority_out), 64'(NONE));
        checkOutput("reset_pending",  64'(bus.event_pending), 64'd0);
        checkOutput("reset_pend_vec", bus.pending_out, 64'd0);
        checkOutput("reset_overflow", 64'(bus.overflow_any), 64'd0);
        rst = 1'b0;
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_priority", 64'(bus.priority_out), 64'(NONE));

        // Channels 5 and 2 together: 2 wins, then 5, then none
        applyStimulus(chan(5) | chan(2), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("pair_priority", 64'(bus.priority_out), 64'd2);
        checkOutput("pair_pending",  64'(bus.event_pending), 64'd1);
        checkOutput("pair_pend_vec", bus.pending_out, 64'h24);
        applyStimulus(64'd0, 16'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ack2_priority", 64'(bus.priority_out), 64'd5);
        checkOutput("ack2_pend_vec", bus.pending_out, 64'h20);
        applyStimulus(64'd0, 16'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ack5_priority", 64'(bus.priority_out), 64'(NONE));
        checkOutput("ack5_pending",  64'(bus.event_pending), 64'd0);

        // Channel 3 double edge before ack -> overflow
        applyStimulus(chan(3), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0,   16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_first_none", 64'(bus.overflow_any), 64'd0);
        applyStimulus(chan(3), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0,   16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set",      64'(bus.overflow_any), 64'd1);
        checkOutput("ovf_priority", 64'(bus.priority_out), 64'd3);
        applyStimulus(64'd0, 16'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_cleared",  64'(bus.overflow_any), 64'd0);
        checkOutput("ack3_priority", 64'(bus.priority_out), 64'(NONE));
        checkOutput("ack3_pend_vec", bus.pending_out, 64'd0);

        // Edge on 4 in the same cycle as ack 4 while already captured
        applyStimulus(chan(4), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0,   16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ch4_priority", 64'(bus.priority_out), 64'd4);
        applyStimulus(chan(4), 16'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0,   16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ch4_edge_ack_priority", 64'(bus.priority_out), 64'd4);
        checkOutput("ch4_edge_ack_overflow", 64'(bus.overflow_any), 64'd0);
        applyStimulus(64'd0, 16'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ch4_ack_priority", 64'(bus.priority_out), 64'(NONE));

        // Mask channel 0, fire 0 and 7, then re-enable 0
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(chan(0) | chan(7), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("masked_priority", 64'(bus.priority_out), 64'd7);
        checkOutput("masked_pend_vec", bus.pending_out, 64'h81);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("unmask_same_edge", 64'(bus.priority_out), 64'd7);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("unmask_priority", 64'(bus.priority_out), 64'd0);
        applyStimulus(64'd0, 16'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd7, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ack07_priority", 64'(bus.priority_out), 64'(NONE));

        // Level channel 1 held high survives an ack
        applyStimulus(chan(1), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(chan(1), 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("level_priority", 64'(bus.priority_out), 64'd1);
        applyStimulus(chan(1), 16'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(chan(1), 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("level_ack_held", 64'(bus.priority_out), 64'd1);
        checkOutput("level_no_ovf",   64'(bus.overflow_any), 64'd0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("level_ack_drop", 64'(bus.priority_out), 64'(NONE));

        // Set beats clear on the same index; out-of-range strobes are ignored
        applyStimulus(chan(9), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd9, 1'b0, 1'b1, 1'b1);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("set_wins_priority", 64'(bus.priority_out), 64'd9);
        applyStimulus(64'd0, 16'd73, 1'b0, 1'b0, 1'b1);
        applyStimulus(64'd0, 16'd73, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd64, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("oob_priority", 64'(bus.priority_out), 64'd9);
        checkOutput("oob_pend_vec", bus.pending_out, 64'h200);

        // Second edge on 9 sets overflow, then reset mid-operation
        applyStimulus(chan(9), 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0,   16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ch9_overflow", 64'(bus.overflow_any), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_priority", 64'(bus.priority_out), 64'(NONE));
        checkOutput("async_rst_pending",  64'(bus.event_pending), 64'd0);
        checkOutput("async_rst_pend_vec", bus.pending_out, 64'd0);
        checkOutput("async_rst_overflow", 64'(bus.overflow_any), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_priority", 64'(bus.priority_out), 64'(NONE));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
